hv_core_sequencer: RTL and testbench
====================================

# hv_core_sequencer

Controller that sequences one `core` hypervector datapath. It runs two jobs. In the item-generation job it fills item memory with pseudo-random hypervectors. In the program job it streams 16-bit instructions into the core's `get_v`/`exec` pipeline, buffers `store` results behind a credit-checked skid FIFO for a back-pressured output stream, and completes either a `lastore` or a `wb` write-back. It sits between the host DMA/instruction streams and `core`, and owns `run`.

## Interface
- `DIM`, 1023: MSB index of hypervector; DIM+1 must be a multiple of 32.
- `NUM_ITEMS`, 1024: item-memory entries written by GEN; 1..1024.
- `FIFO_DEPTH`, 4: result skid FIFO entries; power of 2, ≥4.
- `SEED`, 32'h2545F491: base seed for random lanes.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_gen`, `start_run` in 1: job start pulses, sampled in IDLE only.
- `busy` out 1: state≠IDLE. `done` out 1: one-cycle pulse on job end.
- `inst_valid` in 1, `inst_data` in 16, `inst_ready` out 1: instruction stream.
- `res_valid` out 1, `res_data` out DIM+1, `res_last` out 1, `res_ready` in 1: result stream.
- `wbd_valid` in 1, `wbd_data` in DIM+1, `wbd_ready` out 1: write-back vector input.
- Core side (all outputs registered): `run`, `gen`, `update_item` out 1; `item_a` out 10; `rand_num` out DIM+1; `get_v` out 1; `get_d` out 16; `exec` out 1; `wb_en` out 1; `wb_data` out DIM+1.
- Core side inputs: `store` in 1, `core_result` in DIM+1, `last` in 1.

## Operation
- States: IDLE, GEN, RUN, DRAIN, WB, FLUSH, DONE.
- IDLE:
  - `start_gen` → GEN.
  - else `start_run` → RUN.
  - If both are high, gen wins.
  - Starts are ignored outside IDLE.
- GEN:
  - `gen` = `update_item` = 1 while `item_a` counts 0..NUM_ITEMS-1.
  - `rand_num` advances every cycle.
  - After index NUM_ITEMS-1 → DONE.
- RUN:
  - `run` = 1 (RUN, DRAIN, WB, FLUSH).
  - Instruction accepted on `inst_valid & inst_ready`.
  - `inst_ready` = (state==RUN) & (fifo_count + inflight < FIFO_DEPTH).
  - Accepted word drives `get_v` = 1, `get_d` = word next cycle. `exec` is `get_v` delayed one cycle.
  - inflight counts accepted store/lastore words (inst[15]=0, inst[14:12]=0, inst[11]|inst[10]) not yet seen as `store`.
  - Terminal words:
    - lastore: inst[15]=0, inst[14:11]=0, inst[10]=1.
    - wb: inst[15]=1, inst[14:11]=0, inst[10]=1.
  - Terminal word → DRAIN with `inst_ready` = 0; record which kind it was.
- `store` = 1 pushes `core_result` into FIFO. Entry tagged last if it coincides with `last` and terminal is lastore.
- DRAIN: wait for core `last`. lastore → FLUSH; wb → WB.
- WB:
  - `wbd_ready` = 1.
  - On `wbd_valid`, register `wb_en` = 1 and `wb_data` = `wbd_data` for exactly one cycle, then → FLUSH.
- FLUSH: wait for FIFO empty → DONE.
- DONE: `done` = 1, `run` = 0 → IDLE.
- FIFO output: `res_valid` = !empty, `res_data` = head, `res_last` = head tag. Pop on `res_valid & res_ready`.
- No overflow is possible by construction; a push when full is an assertion failure.

## Timing
- Reset values: all outputs 0; state IDLE; counters and FIFO cleared; random lanes reloaded with seeds.
- Reset mid-job aborts immediately: `run` drops, FIFO empties, no `done`.
- Instruction pipeline: accept at T, `get_v` at T+1, `exec` at T+2, core `store` at T+3, `res_valid` at T+4 earliest.
- Throughput is one instruction per cycle while credit allows.
- Simultaneous push and pop when full or empty is legal; count unchanged.
- GEN lasts exactly NUM_ITEMS cycles from the cycle after `start_gen`. `done` follows the cycle after the last item.
- `wb_en` asserts at least 2 cycles after core `last`, so the core's `wb_ok` is already set.
- `gen`/`item_a`/`rand_num` change together on the same edge.

## Structure
- Package `hv_pkg`:
  - `state_t` enum.
  - Opcode bit-position constants: ADDR=15, LOAD=14, RSH/LLOAD=13, XOR=12, STORE/LXOR=11, LAST/WB=10, MOVE=9.
  - Predicate functions `is_store`, `is_terminal`, `is_wb`.
- Sub-module `hv_rand_gen`:
  - (DIM+1)/32 xorshift32 lanes; lane k seeded SEED + k·32'h9E3779B9.
  - `en` input advances all lanes; output is the concatenation.
- FIFO inline (count, rd/wr pointers, tag bit per entry).

## Test plan
- Reset, NUM_ITEMS=8, `start_gen` → `gen` high 8 cycles, `item_a` 0..7, 8 distinct `rand_num`, one `done`, `busy` low after.
- `start_run`, stream load(0x8003), store(0x0800), lastore(0x0400) with `res_ready`=1 → two results, second with `res_last`=1, `inst_ready`=0 after lastore, `done` after FIFO empties.
- `res_ready`=0, stream 6 stores + lastore → at most 4 entries buffered, `inst_ready` low until pops. Releasing `res_ready` delivers all 7 in order.
- wb word 0x8405, `wbd_valid` delayed 5 cycles with pattern 0xA5.. → exactly one `wb_en` pulse carrying the pattern, then `done`.
- `start_gen` and `start_run` same cycle → GEN only. `start_run` while busy → ignored.
- `rst_n` low during RUN with 3 buffered results → all outputs 0 at once, `res_valid` 0, no `done`.

Source files
------------

// File: rtl/hv_core_sequencer_pkg.sv
// Purpose: sequencer states, instruction bit positions and decode/random helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package hv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GEN   = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WB    = 3'd4,
      ST_FLUSH = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // Bit positions inside a 16-bit instruction word; some bits carry two meanings.
   localparam int OP_ADDR  = 15;
   localparam int OP_LOAD  = 14;
   localparam int OP_RSH   = 13;
   localparam int OP_LLOAD = 13;
   localparam int OP_XOR   = 12;
   localparam int OP_STORE = 11;
   localparam int OP_LXOR  = 11;
   localparam int OP_LAST  = 10;
   localparam int OP_WB    = 10;
   localparam int OP_MOVE  = 9;

   // Word that makes the core emit a result (plain store or last-store).
   function automatic logic is_store(input logic [15:0] w);
      return !w[OP_ADDR] && !w[OP_LOAD] && !w[OP_RSH] && !w[OP_XOR] &&
             (w[OP_STORE] || w[OP_LAST]);
   endfunction

   // Word that ends the instruction stream (lastore or wb).
   function automatic logic is_terminal(input logic [15:0] w);
      return !w[OP_LOAD] && !w[OP_LLOAD] && !w[OP_XOR] && !w[OP_LXOR] && w[OP_LAST];
   endfunction

   // Terminal word that finishes with a write-back instead of a last-store.
   function automatic logic is_wb(input logic [15:0] w);
      return w[OP_ADDR] && !w[OP_LOAD] && !w[OP_LLOAD] && !w[OP_XOR] && !w[OP_LXOR] &&
             w[OP_WB];
   endfunction

   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

endpackage

// File: rtl/hv_core_sequencer_if.sv
// Purpose: host-side streams of the sequencer (instructions, results, write-back data).
// Latency: none (wiring only).
// Backpressure: valid/ready on every stream; the master is the host side.
interface hv_core_sequencer_if #(
   parameter int DIM = 1023
);
   logic          inst_valid;
   logic [15:0]   inst_data;
   logic          inst_ready;
   logic          res_valid;
   logic [DIM:0]  res_data;
   logic          res_last;
   logic          res_ready;
   logic          wbd_valid;
   logic [DIM:0]  wbd_data;
   logic          wbd_ready;

   modport master (
      output inst_valid, inst_data, res_ready, wbd_valid, wbd_data,
      input  inst_ready, res_valid, res_data, res_last, wbd_ready
   );

   modport slave (
      input  inst_valid, inst_data, res_ready, wbd_valid, wbd_data,
      output inst_ready, res_valid, res_data, res_last, wbd_ready
   );
endinterface

// File: rtl/hv_core_sequencer_rand_gen.sv
// Purpose: bank of 32-bit xorshift lanes forming one wide pseudo-random hypervector.
// Latency: output is the current lane state; advances one step per cycle with en.
// Backpressure: none; en simply holds the lanes when low.
module hv_rand_gen
   import hv_pkg::*;
#(
   parameter int          DIM  = 1023,
   parameter logic [31:0] SEED = 32'h2545F491
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [DIM:0] rnd
);
   localparam int LANES = (DIM + 1) / 32;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      // Golden-ratio spacing keeps the lane seeds well apart.
      localparam logic [31:0] LANE_SEED = SEED + 32'(k) * 32'h9E3779B9;
      logic [31:0] lane_q, lane_d;

      // Next lane value: one xorshift step when enabled.
      always_comb begin
         lane_d = lane_q;
         if (en) lane_d = xorshift32(lane_q);
      end

      // Lane register, reloaded with its seed on reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) lane_q <= LANE_SEED;
         else        lane_q <= lane_d;
      end

      assign rnd[k*32 +: 32] = lane_q;
   end
endmodule

// File: rtl/hv_core_sequencer.sv
// Purpose: sequences one hypervector core: item-memory generation and instruction programs.
// Latency: instruction accept at T -> get_v T+1, exec T+2, result visible at T+4 at the earliest.
// Backpressure: inst_ready only while FIFO occupancy plus in-flight stores leaves a free slot.
module hv_core_sequencer
   import hv_pkg::*;
#(
   parameter int          DIM        = 1023,
   parameter int          NUM_ITEMS  = 1024,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] SEED       = 32'h2545F491
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_gen,
   input  logic                  start_run,
   output logic                  busy,
   output logic                  done,
   hv_core_sequencer_if.slave    bus,
   output logic                  run,
   output logic                  gen,
   output logic                  update_item,
   output logic [9:0]            item_a,
   output logic [DIM:0]          rand_num,
   output logic                  get_v,
   output logic [15:0]           get_d,
   output logic                  exec,
   output logic                  wb_en,
   output logic [DIM:0]          wb_data,
   input  logic                  store,
   input  logic [DIM:0]          core_result,
   input  logic                  last
);
   localparam int             PW       = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]    CNT_ONE  = 1;
   localparam logic [PW-1:0]  PTR_ONE  = 1;
   localparam logic [PW+1:0]  CREDITS  = (PW+2)'(FIFO_DEPTH);
   localparam logic [9:0]     LAST_IDX = 10'(NUM_ITEMS - 1);

   state_t state_q, state_d;
   logic              gen_q, gen_d, run_q, run_d, get_v_q, get_v_d, exec_q, exec_d;
   logic              wb_en_q, wb_en_d, term_wb_q, term_wb_d;
   logic [9:0]        item_a_q, item_a_d;
   logic [DIM:0]      rand_num_q, rand_num_d, wb_data_q, wb_data_d, rnd;
   logic [15:0]       get_d_q, get_d_d;
   logic [PW:0]       count_q, count_d, inflight_q, inflight_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_DEPTH-1:0] tag_q, tag_d;
   logic [DIM:0]      mem_q [FIFO_DEPTH];
   logic              gen_step, inst_acc, fifo_empty, fifo_full, push, pop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
   assign bus.inst_ready = (state_q == ST_RUN) && (({1'b0, count_q} + {1'b0, inflight_q}) < CREDITS);
   assign inst_acc   = bus.inst_valid && bus.inst_ready;
   assign push       = store;
   assign pop        = !fifo_empty && bus.res_ready;

   hv_rand_gen #(.DIM(DIM), .SEED(SEED)) u_rand (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (gen_step),
      .rnd   (rnd)
   );

   // Job state machine; gen_step marks every cycle that loads one item.
   always_comb begin
      state_d  = state_q;
      gen_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_gen) begin
               state_d  = ST_GEN;
               gen_step = 1'b1;
            end else if (start_run) begin
               state_d  = ST_RUN;
            end
         end
         ST_GEN: begin
            if (item_a_q == LAST_IDX) state_d  = ST_DONE;
            else                      gen_step = 1'b1;
         end
         ST_RUN:   if (inst_acc && is_terminal(bus.inst_data)) state_d = ST_DRAIN;
         ST_DRAIN: if (last) state_d = term_wb_q ? ST_WB : ST_FLUSH;
         ST_WB:    if (bus.wbd_valid) state_d = ST_FLUSH;
         ST_FLUSH: if (fifo_empty) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Registered core-side controls, credit tracking and FIFO bookkeeping.
   always_comb begin
      gen_d      = gen_step;
      item_a_d   = '0;
      rand_num_d = '0;
      if (gen_step) begin
         item_a_d   = (state_q == ST_GEN) ? item_a_q + 10'd1 : 10'd0;
         rand_num_d = rnd;
      end
      run_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN) ||
                (state_d == ST_WB)  || (state_d == ST_FLUSH);
      get_v_d = inst_acc;
      get_d_d = inst_acc ? bus.inst_data : get_d_q;
      exec_d  = get_v_q;

      wb_en_d   = (state_q == ST_WB) && bus.wbd_valid;
      wb_data_d = wb_en_d ? bus.wbd_data : wb_data_q;

      term_wb_d = term_wb_q;
      if (state_q == ST_IDLE) term_wb_d = 1'b0;
      if (inst_acc && is_terminal(bus.inst_data)) term_wb_d = is_wb(bus.inst_data);

      // A store word holds a credit from acceptance until its result arrives.
      inflight_d = inflight_q;
      if (inst_acc && is_store(bus.inst_data)) inflight_d = inflight_d + CNT_ONE;
      if (store && (inflight_q != '0))         inflight_d = inflight_d - CNT_ONE;

      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      tag_d    = tag_q;
      if (push) begin
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
         tag_d[wr_ptr_q] = last && !term_wb_q;
         count_d         = count_d + CNT_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         count_d  = count_d - CNT_ONE;
      end
   end

   // State and control registers; reset aborts any job without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gen_q      <= 1'b0;
         item_a_q   <= '0;
         rand_num_q <= '0;
         run_q      <= 1'b0;
         get_v_q    <= 1'b0;
         get_d_q    <= '0;
         exec_q     <= 1'b0;
         wb_en_q    <= 1'b0;
         wb_data_q  <= '0;
         term_wb_q  <= 1'b0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         gen_q      <= gen_d;
         item_a_q   <= item_a_d;
         rand_num_q <= rand_num_d;
         run_q      <= run_d;
         get_v_q    <= get_v_d;
         get_d_q    <= get_d_d;
         exec_q     <= exec_d;
         wb_en_q    <= wb_en_d;
         wb_data_q  <= wb_data_d;
         term_wb_q  <= term_wb_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tag_q      <= tag_d;
      end
   end

   // Result storage; contents are don't-care until a push makes them visible.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= core_result;
   end

   // The credit check keeps occupancy plus in-flight stores within the depth.
   assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

   assign bus.res_valid = !fifo_empty;
   assign bus.res_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
   assign bus.res_last  = !fifo_empty && tag_q[rd_ptr_q];
   assign bus.wbd_ready = (state_q == ST_WB);

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign run         = run_q;
   assign gen         = gen_q;
   assign update_item = gen_q;
   assign item_a      = item_a_q;
   assign rand_num    = rand_num_q;
   assign get_v       = get_v_q;
   assign get_d       = get_d_q;
   assign exec        = exec_q;
   assign wb_en       = wb_en_q;
   assign wb_data     = wb_data_q;
endmodule

// File: tb/tb_hv_core_sequencer.sv
// Purpose: self-checking bench for hv_core_sequencer with a small behavioural core model.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: drives res_ready and wbd_valid from per-job schedules.
module tb_hv_core_sequencer;
   localparam int DIM = 63;
   localparam int NI  = 8;
   localparam int FD  = 4;

   logic clk = 1'b0, rst_n = 1'b0, start_gen = 1'b0, start_run = 1'b0;
   logic busy, done, run, gen, update_item, get_v, exec, wb_en;
   logic [9:0]   item_a;
   logic [DIM:0] rand_num, wb_data;
   logic [15:0]  get_d;
   logic         core_store, core_last;
   logic [DIM:0] core_res;
   logic [15:0]  pend;
   logic [15:0]  kcnt;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   hv_core_sequencer_if #(.DIM(DIM)) bus ();

   hv_core_sequencer #(.DIM(DIM), .NUM_ITEMS(NI), .FIFO_DEPTH(FD), .SEED(32'h2545F491)) dut (
      .clk(clk), .rst_n(rst_n), .start_gen(start_gen), .start_run(start_run),
      .busy(busy), .done(done), .bus(bus), .run(run), .gen(gen), .update_item(update_item),
      .item_a(item_a), .rand_num(rand_num), .get_v(get_v), .get_d(get_d), .exec(exec),
      .wb_en(wb_en), .wb_data(wb_data), .store(core_store), .core_result(core_res), .last(core_last)
   );

   function automatic logic tb_is_store(input logic [15:0] w);
      return (w[15:12] == 4'h0) && (w[11] || w[10]);
   endfunction
   function automatic logic tb_is_term(input logic [15:0] w);
      return (w[14:11] == 4'h0) && w[10];
   endfunction
   function automatic logic [31:0] ref_xs(input logic [31:0] v);
      v = v ^ (v << 13);
      v = v ^ (v >> 17);
      v = v ^ (v << 5);
      return v;
   endfunction

   // Core model: word latched on get_v, result/last one cycle after exec.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0; core_store <= 1'b0; core_last <= 1'b0; core_res <= '0; kcnt <= '0;
      end else begin
         if (get_v) pend <= get_d;
         core_store <= exec && tb_is_store(pend);
         core_last  <= exec && tb_is_term(pend);
         if (exec && tb_is_store(pend)) begin
            core_res <= {16'hBEEF, kcnt, 16'h0000, pend};
            kcnt     <= kcnt + 16'd1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, " ctl"}, 64'({busy, done, run, gen, update_item, get_v, exec, wb_en,
                              bus.res_valid, bus.res_last, bus.inst_ready, bus.wbd_ready}), 64'h0);
      chk({tag, " item_a"}, 64'(item_a), 64'h0);
      chk({tag, " rand_num"}, rand_num, 64'h0);
      chk({tag, " get_d"}, 64'(get_d), 64'h0);
      chk({tag, " wb_data"}, wb_data, 64'h0);
      chk({tag, " res_data"}, bus.res_data, 64'h0);
   endtask

   // Per-job observations filled by run_job.
   logic [15:0] prog [8];
   logic [63:0] got_d [$];
   logic        got_l [$];
   logic [63:0] wb_seen;
   int n_acc, n_done, n_wb, done_with_data, ready_after_term, pipe_err;
   int acc_before_rel, rdy_before_rel, vld_before_rel;
   int last_cyc, wb_cyc, first_store_acc, first_res_cyc;

   task automatic run_job(input string tag, input int n, input int rel_at, input int wbd_delay,
                          input int max_cyc, input bit want_done);
      int idx = 0, wb_wait = 0;
      bit acc, prev_acc = 0, prev2_acc = 0, wb_hs, wb_sent = 0, saw_done;
      logic [15:0] prev_w = '0, w_now;
      got_d.delete(); got_l.delete();
      n_done = 0; n_wb = 0; done_with_data = 0; ready_after_term = 0; pipe_err = 0;
      acc_before_rel = -1; rdy_before_rel = -1; vld_before_rel = -1;
      last_cyc = -1; wb_cyc = -1; first_store_acc = -1; first_res_cyc = -1;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         if (get_v !== prev_acc) pipe_err++;
         if (prev_acc && (get_d !== prev_w)) pipe_err++;
         if (exec !== prev2_acc) pipe_err++;
         if (core_last && last_cyc < 0) last_cyc = cyc;
         if (wb_en) begin n_wb++; wb_seen = wb_data; if (wb_cyc < 0) wb_cyc = cyc; end
         saw_done = done;
         if (done) begin n_done++; if (bus.res_valid) done_with_data++; end
         if (bus.res_valid && first_res_cyc < 0) first_res_cyc = cyc;
         bus.inst_valid = (idx < n);
         w_now          = (idx < n) ? prog[idx] : 16'h0;
         bus.inst_data  = w_now;
         bus.res_ready  = (cyc >= rel_at);
         if (!wb_sent && bus.wbd_ready) begin
            if (wb_wait >= wbd_delay) bus.wbd_valid = 1'b1;
            else wb_wait++;
         end
         if (idx >= n && bus.inst_ready) ready_after_term++;
         if (cyc == rel_at - 1) begin
            acc_before_rel = idx; rdy_before_rel = int'(bus.inst_ready); vld_before_rel = int'(bus.res_valid);
         end
         acc = bus.inst_valid && bus.inst_ready;
         if (acc && tb_is_store(w_now) && first_store_acc < 0) first_store_acc = cyc;
         if (bus.res_valid && bus.res_ready) begin
            got_d.push_back(bus.res_data);
            got_l.push_back(bus.res_last);
         end
         wb_hs = bus.wbd_valid && bus.wbd_ready;
         tick();
         prev2_acc = prev_acc; prev_acc = acc; prev_w = w_now;
         if (acc) idx++;
         if (wb_hs) begin wb_sent = 1'b1; bus.wbd_valid = 1'b0; end
         if (saw_done) break;
      end
      bus.inst_valid = 1'b0;
      bus.wbd_valid  = 1'b0;
      n_acc = idx;
      chki({tag, " pipeline"}, pipe_err, 0);
      if (want_done) begin
         chki({tag, " done pulses"}, n_done, 1);
         chki({tag, " done with data"}, done_with_data, 0);
         chk({tag, " busy after"}, 64'(busy), 64'h0);
      end
   endtask

   typedef struct {
      logic sg, sr, e_busy, e_done, e_gen, e_run;
      logic [9:0] e_item;
   } gen_vec_t;

   initial begin
      gen_vec_t tbl [10];
      logic [31:0] ml0, ml1;

      bus.inst_valid = 1'b0; bus.inst_data = '0; bus.res_ready = 1'b0;
      bus.wbd_valid = 1'b0; bus.wbd_data = {8{8'hA5}};

      // Both starts in the first row (gen wins); later starts are ignored while busy.
      tbl[0] = '{1, 1, 1, 0, 1, 0, 10'd0};
      tbl[1] = '{0, 0, 1, 0, 1, 0, 10'd1};
      tbl[2] = '{0, 1, 1, 0, 1, 0, 10'd2};
      tbl[3] = '{1, 0, 1, 0, 1, 0, 10'd3};
      tbl[4] = '{0, 0, 1, 0, 1, 0, 10'd4};
      tbl[5] = '{0, 0, 1, 0, 1, 0, 10'd5};
      tbl[6] = '{0, 1, 1, 0, 1, 0, 10'd6};
      tbl[7] = '{0, 0, 1, 0, 1, 0, 10'd7};
      tbl[8] = '{0, 0, 1, 1, 0, 0, 10'd0};
      tbl[9] = '{0, 0, 0, 0, 0, 0, 10'd0};

      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      ml0 = 32'h2545F491;
      ml1 = 32'hC37D6E4A;
      for (int i = 0; i < 10; i++) begin
         start_gen = tbl[i].sg;
         start_run = tbl[i].sr;
         tick();
         chk($sformatf("gen row%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
         chk($sformatf("gen row%0d done", i), 64'(done), 64'(tbl[i].e_done));
         chk($sformatf("gen row%0d gen", i), 64'(gen), 64'(tbl[i].e_gen));
         chk($sformatf("gen row%0d update_item", i), 64'(update_item), 64'(tbl[i].e_gen));
         chk($sformatf("gen row%0d run", i), 64'(run), 64'(tbl[i].e_run));
         chk($sformatf("gen row%0d item_a", i), 64'(item_a), 64'(tbl[i].e_item));
         if (tbl[i].e_gen) begin
            chk($sformatf("gen row%0d rand_num", i), rand_num, {ml1, ml0});
            ml0 = ref_xs(ml0);
            ml1 = ref_xs(ml1);
         end else begin
            chk($sformatf("gen row%0d rand_num", i), rand_num, 64'h0);
         end
      end
      start_gen = 1'b0;
      start_run = 1'b0;

      // load, store, lastore with the result stream always ready.
      prog[0] = 16'h8003; prog[1] = 16'h0800; prog[2] = 16'h0400;
      start_run = 1'b1; tick(); start_run = 1'b0;
      chk("A run", 64'({busy, run}), 64'h3);
      run_job("A", 3, 0, 0, 60, 1'b1);
      chki("A results", got_d.size(), 2);
      chk("A res0", got_d[0], 64'hBEEF_0000_0000_0800);
      chk("A res1", got_d[1], 64'hBEEF_0001_0000_0400);
      chk("A last flags", 64'({got_l[0], got_l[1]}), 64'h1);
      chki("A ready after lastore", ready_after_term, 0);
      chki("A accept-to-result", first_res_cyc - first_store_acc, 4);

      // Six stores and a lastore against a stalled result stream.
      for (int i = 0; i < 6; i++) prog[i] = 16'h0800;
      prog[6] = 16'h0400;
      start_run = 1'b1; tick(); start_run = 1'b0;
      run_job("B", 7, 20, 0, 120, 1'b1);
      chki("B accepted while stalled", acc_before_rel, FD);
      chki("B ready while stalled", rdy_before_rel, 0);
      chki("B valid while stalled", vld_before_rel, 1);
      chki("B results", got_d.size(), 7);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("B res%0d", i), got_d[i],
             {16'hBEEF, 16'(2 + i), 16'h0000, (i < 6) ? 16'h0800 : 16'h0400});
         chk($sformatf("B last%0d", i), 64'(got_l[i]), (i == 6) ? 64'h1 : 64'h0);
      end

      // Write-back terminal with the data arriving five cycles late.
      prog[0] = 16'h8405;
      start_run = 1'b1; tick(); start_run = 1'b0;
      run_job("C", 1, 0, 5, 80, 1'b1);
      chki("C results", got_d.size(), 0);
      chki("C wb_en pulses", n_wb, 1);
      chk("C wb_data", wb_seen, {8{8'hA5}});
      chki("C wb after last", int'((last_cyc >= 0) && (wb_cyc - last_cyc >= 2)), 1);

      // Reset in the middle of a run with three results buffered.
      prog[0] = 16'h0800; prog[1] = 16'h0800; prog[2] = 16'h0800;
      start_run = 1'b1; tick(); start_run = 1'b0;
      run_job("R", 3, 1000, 0, 10, 1'b0);
      chki("R accepted", n_acc, 3);
      chk("R buffered", 64'({busy, run, bus.res_valid}), 64'h7);
      rst_n = 1'b0;
      #1;
      chk_zero("R reset");
      n_done = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (done) n_done++; end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin tick(); if (done || bus.res_valid || busy) n_done++; end
      chki("R no done after abort", n_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1);
   end
endmodule
